// File: rtl/ltscope_capture_ctrl.sv
// ltscope_capture_ctrl
// Capture sequencer for the LTscope ring buffer. It drives the enable of
// ring_buffer_addr and watches its write address. The sequence is
// arm -> pre-trigger fill -> wait-for-trigger -> post-trigger fill -> done.
// The ring address of the trigger sample is latched so that readout can
// unroll the circular capture into time order.
//
// Optional build macro: LTSCOPE_TRIG_TIMEOUT_EN
//   When defined, WAIT_TRIG forces a trigger after TIMEOUT_CYC cycles with
//   no edge, and forced_trig reports it. When undefined, WAIT_TRIG waits
//   indefinitely and forced_trig is always 0.
//
// Ports:
//   clk          system clock (single domain)
//   rst          synchronous active-high reset
//   arm          single-cycle pulse, starts a capture (IDLE/DONE only)
//   abort        single-cycle pulse, cancels any capture
//   trig_in      trigger level, synchronous to clk (rising edge fires)
//   depth        ring depth in samples, sampled on accepted arm
//   pretrig      samples kept before the trigger, sampled on accepted arm
//   wr_addr      current ring write address
//   buf_en       ring buffer enable, one sample per cycle while high
//   trig_addr    wr_addr in the trigger cycle
//   busy         high in PREFILL, WAIT_TRIG and POST
//   done         high in DONE
//   state        IDLE=0 PREFILL=1 WAIT_TRIG=2 POST=3 DONE=4
//   forced_trig  last trigger came from the timeout
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | no capture in progress, buffer disabled
// PREFILL   | filling pretrigger samples, triggers ignored
// WAIT_TRIG | buffer running, waiting for a trig_in rising edge
// POST      | filling the remaining post-trigger samples
// DONE      | capture complete, buffer disabled, waits for arm/abort

module ltscope_capture_ctrl #(
  parameter int unsigned ADDR_W      = 29,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_in,
  input  logic [ADDR_W-1:0] depth,
  input  logic [ADDR_W-1:0] pretrig,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              buf_en,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state,
  output logic              forced_trig
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREFILL   = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t            st;
  logic              trig_q;
  logic [ADDR_W-1:0] depth_r;
  logic [ADDR_W-1:0] pre_r;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;

  logic              trig_edge;
  logic              arm_ok;
  logic [ADDR_W-1:0] depth_m1;
  logic [ADDR_W-1:0] pre_clamped;
  logic [ADDR_W-1:0] post_init;
  logic              fire;
  logic              fire_forced;

  assign state       = st;
  assign trig_edge   = trig_in & ~trig_q;
  assign arm_ok      = arm && ((st == S_IDLE) || (st == S_DONE)) &&
                       (depth >= ADDR_W'(2));
  assign depth_m1    = depth - ADDR_W'(1);
  assign pre_clamped = (pretrig > depth_m1) ? depth_m1 : pretrig;
  // The trigger-cycle sample is the first post-trigger sample, hence the -1.
  assign post_init   = depth_r - pre_r - ADDR_W'(1);

`ifdef LTSCOPE_TRIG_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        timeout_hit;

  assign timeout_hit = (wait_cnt == 32'(TIMEOUT_CYC - 1));
  assign fire        = trig_edge | timeout_hit;
  // A real edge in the timeout cycle wins, so it is not reported as forced.
  assign fire_forced = timeout_hit & ~trig_edge;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYC;
  assign fire           = trig_edge;
  assign fire_forced    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      trig_q      <= 1'b0;
      depth_r     <= '0;
      pre_r       <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      buf_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      forced_trig <= 1'b0;
      trig_addr   <= '0;
`ifdef LTSCOPE_TRIG_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      // Tracks trig_in in every state so a level that is already high on
      // entering WAIT_TRIG must fall and rise again before it fires.
      trig_q <= trig_in;

      if (abort) begin
        st     <= S_IDLE;
        buf_en <= 1'b0;
        busy   <= 1'b0;
        done   <= 1'b0;
      end else begin
        case (st)
          S_IDLE, S_DONE: begin
            if (arm_ok) begin
              depth_r     <= depth;
              pre_r       <= pre_clamped;
              pre_cnt     <= '0;
              done        <= 1'b0;
              forced_trig <= 1'b0;
              buf_en      <= 1'b1;
              busy        <= 1'b1;
              st          <= S_PREFILL;
            end
          end

          S_PREFILL: begin
            pre_cnt <= pre_cnt + ADDR_W'(1);
            if (pre_cnt == pre_r) begin
              st <= S_WAIT_TRIG;
`ifdef LTSCOPE_TRIG_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end
          end

          S_WAIT_TRIG: begin
`ifdef LTSCOPE_TRIG_TIMEOUT_EN
            wait_cnt <= wait_cnt + 32'd1;
`endif
            if (fire) begin
              trig_addr   <= wr_addr;
              forced_trig <= fire_forced;
              post_cnt    <= post_init;
              if (post_init == '0) begin
                st     <= S_DONE;
                buf_en <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                st <= S_POST;
              end
            end
          end

          S_POST: begin
            post_cnt <= post_cnt - ADDR_W'(1);
            if (post_cnt == ADDR_W'(1)) begin
              st     <= S_DONE;
              buf_en <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end

          default: begin
            st     <= S_IDLE;
            buf_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ltscope_capture_ctrl.sv
// Testbench for ltscope_capture_ctrl. Stimulus pushes expected output
// snapshots and expected capture results into queues; a negedge monitor
// pops and compares them against what the DUT presents.
module tb_ltscope_capture_ctrl;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst, arm, abort, trig_in;
  logic [AW-1:0] depth, pretrig, wr_addr;
  logic          buf_en, busy, done, forced_trig;
  logic [AW-1:0] trig_addr;
  logic [2:0]    state;

  always #5 clk = ~clk;

  ltscope_capture_ctrl #(.ADDR_W(AW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_in(trig_in),
    .depth(depth), .pretrig(pretrig), .wr_addr(wr_addr),
    .buf_en(buf_en), .trig_addr(trig_addr), .busy(busy), .done(done),
    .state(state), .forced_trig(forced_trig)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic          en;
    logic          bsy;
    logic          dn;
    logic          frc;
    logic [AW-1:0] ta;
  } snap_t;

  typedef struct packed {
    logic [AW-1:0] ta;
    logic          frc;
    int            pre_len;
    int            post_len;
  } cap_t;

  snap_t snap_q[$];
  string snap_name_q[$];
  cap_t  cap_q[$];
  string cap_name_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- monitor ----------------
  logic [2:0] prev_state = 3'd0;
  logic       prev_done  = 1'b0;
  int         pre_len    = 0;
  int         post_en    = 0;

  always @(negedge clk) begin
    snap_t s_act, s_exp;
    cap_t  c_act, c_exp;
    string nm;
    s_act = '{st: state, en: buf_en, bsy: busy, dn: done, frc: forced_trig, ta: trig_addr};

    if (state == 3'd1) begin
      if (prev_state != 3'd1) begin
        pre_len = 0;
        post_en = 0;
      end
      if (buf_en) pre_len++;
    end
    if (state == 3'd3 && buf_en) post_en++;

    while (snap_q.size() > 0) begin
      s_exp = snap_q.pop_front();
      nm    = snap_name_q.pop_front();
      n_cmp++;
      if (s_act !== s_exp) begin
        n_bad++;
        $display("FAIL %s: got st=%0d en=%0b busy=%0b done=%0b frc=%0b ta=%0h, want st=%0d en=%0b busy=%0b done=%0b frc=%0b ta=%0h",
                 nm, s_act.st, s_act.en, s_act.bsy, s_act.dn, s_act.frc, s_act.ta,
                 s_exp.st, s_exp.en, s_exp.bsy, s_exp.dn, s_exp.frc, s_exp.ta);
      end
    end

    if (done && !prev_done) begin
      c_act = '{ta: trig_addr, frc: forced_trig, pre_len: pre_len, post_len: post_en + 1};
      n_cmp++;
      if (cap_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: got done with ta=%0h, want no capture completion", trig_addr);
      end else begin
        c_exp = cap_q.pop_front();
        nm    = cap_name_q.pop_front();
        if (c_act !== c_exp || buf_en !== 1'b0) begin
          n_bad++;
          $display("FAIL %s: got ta=%0h frc=%0b pre=%0d post=%0d en=%0b, want ta=%0h frc=%0b pre=%0d post=%0d en=0",
                   nm, c_act.ta, c_act.frc, c_act.pre_len, c_act.post_len, buf_en,
                   c_exp.ta, c_exp.frc, c_exp.pre_len, c_exp.post_len);
        end
      end
    end

    prev_state = state;
    prev_done  = done;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_snap(input string nm, input logic [2:0] st, input logic en,
                          input logic bsy, input logic dn, input logic frc,
                          input logic [AW-1:0] ta);
    snap_t s;
    s = '{st: st, en: en, bsy: bsy, dn: dn, frc: frc, ta: ta};
    snap_q.push_back(s);
    snap_name_q.push_back(nm);
  endtask

  task automatic exp_cap(input string nm, input logic [AW-1:0] ta, input logic frc,
                         input int pre, input int post);
    cap_t c;
    c = '{ta: ta, frc: frc, pre_len: pre, post_len: post};
    cap_q.push_back(c);
    cap_name_q.push_back(nm);
  endtask

  task automatic wait_state(input string nm, input logic [2:0] tgt);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (state == tgt) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: state=%0d after 100 cycles, want %0d", nm, state, tgt);
    end
  endtask

  task automatic do_arm(input logic [AW-1:0] d, input logic [AW-1:0] p);
    depth   = d;
    pretrig = p;
    arm     = 1'b1;
    step();
    arm     = 1'b0;
  endtask

  task automatic pulse_trig(input logic [AW-1:0] a);
    trig_in = 1'b1;
    wr_addr = a;
    step();
    trig_in = 1'b0;
    wr_addr = a + AW'(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_in = 1'b0;
    depth = '0; pretrig = '0; wr_addr = '0;

    // reset, with arm held to confirm reset priority
    step();
    depth = 16; arm = 1'b1;
    step();
    arm = 1'b0;
    exp_snap("reset_state", 3'd0, 0, 0, 0, 0, '0);
    rst = 1'b0;
    step();

    // T1: depth 16, pretrig 4, trigger 10 cycles after WAIT entry at addr 9
    exp_cap("t1_capture", 16'd9, 0, 5, 12);
    do_arm(16, 4);
    exp_snap("t1_prefill_entry", 3'd1, 1, 1, 0, 0, '0);
    depth = 5; pretrig = 0;            // must not affect the running capture
    wait_state("t1_wait_entry", 3'd2);
    wr_addr = 8;
    repeat (10) step();
    pulse_trig(16'd9);
    exp_snap("t1_post", 3'd3, 1, 1, 0, 0, 16'd9);
    wait_state("t1_done_entry", 3'd4);
    exp_snap("t1_done", 3'd4, 0, 0, 1, 0, 16'd9);
    step();

    // T2: pretrig clamped to depth-1, trigger goes straight to DONE
    exp_cap("t2_clamp_capture", 16'd3, 0, 16, 1);
    do_arm(16, 20);
    wait_state("t2_wait_entry", 3'd2);
    repeat (2) step();
    pulse_trig(16'd3);
    exp_snap("t2_done_direct", 3'd4, 0, 0, 1, 0, 16'd3);
    step();

    // T3: trig_in already high on WAIT entry must not fire
    exp_cap("t3_level_capture", 16'd6, 0, 3, 6);
    trig_in = 1'b1;
    wr_addr = 5;
    do_arm(8, 2);
    wait_state("t3_wait_entry", 3'd2);
    repeat (5) step();
    exp_snap("t3_no_fire_on_level", 3'd2, 1, 1, 0, 0, 16'd3);
    trig_in = 1'b0;
    step();
    pulse_trig(16'd6);
    wait_state("t3_done_entry", 3'd4);
    exp_snap("t3_done", 3'd4, 0, 0, 1, 0, 16'd6);
    step();

    // T4a: abort during POST keeps trig_addr
    do_arm(10, 1);
    wait_state("t4_wait_entry", 3'd2);
    pulse_trig(16'd7);
    wait_state("t4_post_entry", 3'd3);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_snap("t4_abort_post", 3'd0, 0, 0, 0, 0, 16'd7);
    step();

    // T4b: reach DONE, then abort + arm together
    exp_cap("t4_short_capture", 16'd2, 0, 1, 4);
    do_arm(4, 0);
    wait_state("t4b_wait_entry", 3'd2);
    pulse_trig(16'd2);
    wait_state("t4b_done_entry", 3'd4);
    step();
    depth = 10; pretrig = 1;
    abort = 1'b1; arm = 1'b1;
    step();
    abort = 1'b0; arm = 1'b0;
    exp_snap("t4_abort_beats_arm", 3'd0, 0, 0, 0, 0, 16'd2);
    step();

    // T4c: arm with depth 1 is ignored
    do_arm(1, 0);
    exp_snap("t4_depth1_ignored", 3'd0, 0, 0, 0, 0, 16'd2);
    step();
    exp_snap("t4_depth1_still_idle", 3'd0, 0, 0, 0, 0, 16'd2);
    step();

    // T5: reset mid-POST clears everything including trig_addr
    do_arm(12, 3);
    wait_state("t5_wait_entry", 3'd2);
    pulse_trig(16'd4);
    step();
    exp_snap("t5_mid_post", 3'd3, 1, 1, 0, 0, 16'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_snap("t5_reset_mid_post", 3'd0, 0, 0, 0, 0, '0);
    step();

`ifdef LTSCOPE_TRIG_TIMEOUT_EN
    // T6: no trigger, forced on 8th WAIT cycle
    exp_cap("t6_forced_capture", 16'h47, 1, 1, 16);
    do_arm(16, 0);
    wait_state("t6_wait_entry", 3'd2);
    for (int i = 0; i < 8; i++) begin
      wr_addr = AW'(16'h40 + i);
      step();
    end
    wait_state("t6_done_entry", 3'd4);
    exp_snap("t6_done_forced", 3'd4, 0, 0, 1, 1, 16'h47);
    step();
    do_arm(16, 0);
    exp_snap("t6_rearm_clears_forced", 3'd1, 1, 1, 0, 0, 16'h47);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif

    repeat (3) step();
    n_cmp++;
    if (cap_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_captures: got %0d uncompleted, want 0", cap_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
